custom_rptr_empty_stream: RTL and testbench
===========================================

Name: custom_rptr_empty_stream

Overview:
- Read-side control for the async FIFO, and the counterpart of the write-pointer/full block.
- Runs in the read clock domain and owns the binary and Gray read pointers.
- Generates registered empty and almost-empty flags against the 2-flop-synchronised write Gray pointer.
- Issues reads to the 1-cycle-latency dual-port RAM and presents data as a valid/ready stream through a 2-entry output buffer, at full throughput.

Parameters:
- ADDRSIZE, 4, RAM address width; FIFO depth = 2**ADDRSIZE.
- DATASIZE, 8, data word width.

Ports:
- rclk_i  input  1  read clock
- rrst_i  input  1  synchronous reset, active-high
- wptr_sync2_rdclk  input  ADDRSIZE+1  write Gray pointer, already synchronised to rclk_i
- rd_en  output  1  RAM read strobe; one entry consumed per asserted cycle
- rd_addr  output  ADDRSIZE  RAM read address (rbin_reg[ADDRSIZE-1:0])
- rd_data_i  input  DATASIZE  RAM read data, valid the cycle after rd_en
- rptr_g  output  ADDRSIZE+1  registered read Gray pointer, to the write-domain synchroniser
- fifo_empty  output  1  registered: RAM holds no unread entry
- fifo_almost_empty  output  1  registered: RAM holds at most 1 unread entry
- dout  output  DATASIZE  stream data (buffer head)
- dout_valid  output  1  stream valid
- dout_ready  input  1  stream ready from consumer

Behaviour:
- Reset (rrst_i=1 at a rclk_i edge) sets:
  - rbin_reg=0, rptr_g=0.
  - fifo_empty=1, fifo_almost_empty=1.
  - Buffer count=0, inflight=0, dout_valid=0, dout=0.
- An in-flight RAM read at reset is discarded; rd_data_i is ignored the following cycle.
- Pop: pop = dout_valid & dout_ready.
- Occupancy: occ = buf_cnt + inflight, range 0..2.
- Issue: rd_en = ~fifo_empty & ((occ - pop) < 2). The combinational path from dout_ready to rd_en is intended.
- Pointer update:
  - rbin_next = rbin_reg + rd_en.
  - rgray_next = (rbin_next>>1) ^ rbin_next.
  - Both are registered every cycle.
  - Wrap-around is natural (ADDRSIZE+1 bits, MSB = lap bit).
- Empty: fifo_empty <= (rgray_next == wptr_sync2_rdclk).
  - After the last entry is read, rd_en drops on the next cycle.
  - A write becomes visible only through wptr_sync2_rdclk.
- Almost-empty:
  - wbin_s = Gray-to-binary(wptr_sync2_rdclk).
  - fifo_almost_empty <= ((wbin_s - rbin_next) mod 2**(ADDRSIZE+1)) <= 1.
- Inflight register: inflight <= rd_en.
  - The cycle after rd_en, rd_data_i is written into the buffer tail.
- Buffer:
  - 2 entries, FIFO order; dout = head; dout_valid = (buf_cnt != 0).
  - A simultaneous push and pop shifts the head and writes the tail in the same cycle, with no bubble.
- Overflow: the issue rule guarantees buf_cnt + inflight never exceeds 2. The bench asserts this.
- Backpressure: with dout_ready=0, at most 2 entries leave the RAM; rd_en stays 0 until a pop.
- Throughput: sustained 1 word/cycle when the FIFO is non-empty and dout_ready=1.
- Latency: first dout_valid appears 2 cycles after fifo_empty falls (rd_en cycle, capture cycle).
- Simultaneous write arrival and last read: the flag follows rgray_next vs. the current synced pointer. No pessimism beyond synchroniser delay.

Optional Feature:
- Macro: CUSTOM_RFIFO_LEVEL_EN.
- Defined: adds output rd_level [ADDRSIZE:0], registered.
  - rd_level <= ((wbin_s - rbin_next) mod 2**(ADDRSIZE+1)) + occ_next, where occ_next is next-cycle buf_cnt + inflight.
  - This is the total words available to the consumer.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package custom_afifo_pkg holds:
  - Function gray2bin and function bin2gray, both parameterised by width via a localparam-sized wrapper.
  - A constant for the output buffer depth, OUTBUF_DEPTH = 2.
- The 2-entry output buffer is a natural sub-module: custom_afifo_outbuf.
  - Ports: push, push_data, pop, head, count; its own synchronous active-high reset.
- Pointer/flag logic stays in the top module.

Test Plan:
- Reset: assert rrst_i 2 cycles with wptr_sync2_rdclk=5'b00011 -> fifo_empty=1, fifo_almost_empty=1, rptr_g=0, dout_valid=0, rd_en=0 during reset.
- Single word: after reset, drive wptr_sync2_rdclk=bin2gray(1)=5'b00001 with RAM word 8'hA5 at address 0 -> fifo_empty falls, rd_en=1 with rd_addr=0 for exactly 1 cycle, dout=8'hA5 with dout_valid 2 cycles later; fifo_empty=1 and rptr_g=5'b00001 afterwards.
- Streaming: load 16 words (wptr=bin2gray(16)=5'b11000) with dout_ready=1 -> 16 consecutive dout_valid beats, data in order, fifo_almost_empty rises when 1 entry remains, fifo_empty=1 after the 16th rd_en, rptr_g=5'b11000.
- Backpressure: 8 words available, dout_ready=0 for 10 cycles -> exactly 2 rd_en pulses, buf_cnt=2. Then dout_ready=1 -> remaining 6 delivered with no gap, no loss or duplication.
- Wrap: pre-advance both pointers to 30 (bin 5'b11110), write 4 more (wptr bin 2, Gray 5'b00011) -> 4 reads at addresses 14, 15, 0, 1; rptr_g ends at 5'b00011; fifo_empty=1.
- Reset mid-operation: assert rrst_i in the cycle after rd_en while rd_data_i=8'h3C -> 8'h3C never appears on dout; all outputs return to reset values next cycle.

Source files
------------

// File: rtl/custom_afifo_pkg.sv
// Shared helpers for the async FIFO read side: Gray/binary pointer
// conversion and the depth of the read-side output buffer.
package custom_afifo_pkg;

    localparam int OUTBUF_DEPTH = 2;

    // Conversions run on a fixed wide word. Callers zero-extend into it and
    // truncate the result, so one function pair serves every pointer width.
    localparam int PTR_MAX_W = 32;
    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/custom_afifo_outbuf.sv
// Two-entry FIFO that holds RAM read data until the consumer accepts it.
// Pop and push in the same cycle shift and refill with no bubble.
module custom_afifo_outbuf
    import custom_afifo_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [DATASIZE-1:0] push_data_i,
    input  logic                pop_i,
    output logic [DATASIZE-1:0] head_o,
    output logic [1:0]          count_o
);

    localparam logic [1:0] CNT_FULL = 2'(OUTBUF_DEPTH);

    logic [DATASIZE-1:0] mem_q [OUTBUF_DEPTH];
    logic [DATASIZE-1:0] mem_d [OUTBUF_DEPTH];
    logic [1:0]          cnt_q;
    logic [1:0]          cnt_d;

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (pop_i && (cnt_q != 2'd0)) begin
            mem_d[0] = mem_q[1];
            cnt_d    = cnt_q - 2'd1;
        end
        // Push lands in the first free slot after any pop has been applied.
        if (push_i && (cnt_d != CNT_FULL)) begin
            mem_d[cnt_d[0]] = push_data_i;
            cnt_d           = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 2'd0;
            for (int i = 0; i < OUTBUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    assign head_o  = mem_q[0];
    assign count_o = cnt_q;

endmodule

// File: rtl/custom_rptr_empty_stream.sv
// Async FIFO read side: read pointers, empty/almost-empty flags, and a
// valid/ready output stream. Optional rd_level output: CUSTOM_RFIFO_LEVEL_EN.
module custom_rptr_empty_stream
    import custom_afifo_pkg::*;
#(
    parameter int ADDRSIZE = 4,
    parameter int DATASIZE = 8
) (
    input  logic                rclk_i,
    input  logic                rrst_i,
    input  logic [ADDRSIZE:0]   wptr_sync2_rdclk,
    output logic                rd_en,
    output logic [ADDRSIZE-1:0] rd_addr,
    input  logic [DATASIZE-1:0] rd_data_i,
    output logic [ADDRSIZE:0]   rptr_g,
    output logic                fifo_empty,
    output logic                fifo_almost_empty,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    input  logic                dout_ready
`ifdef CUSTOM_RFIFO_LEVEL_EN
    ,
    output logic [ADDRSIZE:0]   rd_level
`endif
);

    localparam int PW = ADDRSIZE + 1;

    logic [ADDRSIZE:0] rbin_q;
    logic [ADDRSIZE:0] rptr_g_q;
    logic              empty_q;
    logic              aempty_q;
    logic              inflight_q;

    logic [ADDRSIZE:0] rbin_next;
    logic [ADDRSIZE:0] rgray_next;
    logic [ADDRSIZE:0] wbin_s;
    logic [ADDRSIZE:0] wdist_next;
    logic [1:0]        buf_cnt;
    logic [1:0]        occ;
    logic [1:0]        occ_after;
    logic              pop;

    // Stream handshake: a word transfers on every cycle where dout_valid and
    // dout_ready are both high; dout is held stable while valid and not ready.
    assign dout_valid = (buf_cnt != 2'd0);
    assign pop        = dout_valid & dout_ready;

    // Words in the buffer plus the RAM read still in flight; a read is issued
    // only if there will be room for its data, which this cycle's pop frees.
    assign occ       = buf_cnt + {1'b0, inflight_q};
    assign occ_after = occ - {1'b0, pop};
    assign rd_en     = ~empty_q & (occ_after < 2'd2);

    assign rbin_next  = rbin_q + {{ADDRSIZE{1'b0}}, rd_en};
    assign rgray_next = PW'(bin2gray(PTR_MAX_W'(rbin_next)));
    assign wbin_s     = PW'(gray2bin(PTR_MAX_W'(wptr_sync2_rdclk)));
    assign wdist_next = wbin_s - rbin_next;

    always_ff @(posedge rclk_i) begin
        if (rrst_i) begin
            rbin_q     <= '0;
            rptr_g_q   <= '0;
            empty_q    <= 1'b1;
            aempty_q   <= 1'b1;
            inflight_q <= 1'b0;
        end else begin
            rbin_q     <= rbin_next;
            rptr_g_q   <= rgray_next;
            empty_q    <= (rgray_next == wptr_sync2_rdclk);
            aempty_q   <= (wdist_next <= PW'(1));
            inflight_q <= rd_en;
        end
    end

    assign rd_addr           = rbin_q[ADDRSIZE-1:0];
    assign rptr_g            = rptr_g_q;
    assign fifo_empty        = empty_q;
    assign fifo_almost_empty = aempty_q;

    // Reset clears inflight_q, so data returning from a read issued just
    // before reset is never pushed.
    custom_afifo_outbuf #(
        .DATASIZE (DATASIZE)
    ) u_outbuf (
        .clk_i       (rclk_i),
        .rst_i       (rrst_i),
        .push_i      (inflight_q),
        .push_data_i (rd_data_i),
        .pop_i       (pop),
        .head_o      (dout),
        .count_o     (buf_cnt)
    );

`ifdef CUSTOM_RFIFO_LEVEL_EN
    logic [1:0]        occ_next;
    logic [ADDRSIZE:0] rd_level_q;

    assign occ_next = occ_after + {1'b0, rd_en};

    always_ff @(posedge rclk_i) begin
        if (rrst_i) begin
            rd_level_q <= '0;
        end else begin
            rd_level_q <= wdist_next + PW'(occ_next);
        end
    end

    assign rd_level = rd_level_q;
`else
    // Without the level output, occupancy only steers read issue.
`endif

endmodule

// File: tb/tb_custom_rptr_empty_stream.sv
// Bench for custom_rptr_empty_stream: word-level model, stream scoreboard
// and directed scenarios (reset, single word, streaming, backpressure, wrap).
module tb_custom_rptr_empty_stream;

    logic       rclk_i = 1'b0;
    logic       rrst_i;
    logic [4:0] wptr;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_data_i = 8'h00;
    logic [4:0] rptr_g;
    logic       fifo_empty;
    logic       fifo_almost_empty;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;

    logic [7:0] ram [16];

    custom_rptr_empty_stream #(.ADDRSIZE(4), .DATASIZE(8)) dut (
        .rclk_i            (rclk_i),
        .rrst_i            (rrst_i),
        .wptr_sync2_rdclk  (wptr),
        .rd_en             (rd_en),
        .rd_addr           (rd_addr),
        .rd_data_i         (rd_data_i),
        .rptr_g            (rptr_g),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .dout              (dout),
        .dout_valid        (dout_valid),
        .dout_ready        (dout_ready)
    );

    always #5 rclk_i = ~rclk_i;

    // 1-cycle-latency RAM read port
    always @(posedge rclk_i) begin
        if (rd_en) rd_data_i <= ram[rd_addr];
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ren_cnt = 0;
    int outst = 0;
    bit seen_ren = 0;
    bit seen_pop = 0;
    int beat_cyc[$];
    int addr_log[$];
    logic [7:0] exp_q[$];

    // Word-level model: read count, empty/almost-empty from pointer distance,
    // and the words held for the consumer.
    int         m_rbin = 0;
    bit         m_empty = 1;
    bit         m_aempty = 1;
    bit         m_infl = 0;
    logic [7:0] m_infl_data = 8'h00;
    logic [7:0] m_buf[$];

    function automatic int g2b(input int g);
        int b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        return b;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & 31;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge rclk_i);
        #1;
    endtask

    function automatic bit model_ren();
        int held;
        int pop;
        held = m_buf.size() + int'(m_infl);
        pop  = ((m_buf.size() != 0) && dout_ready) ? 1 : 0;
        return !m_empty && ((held - pop) < 2);
    endfunction

    task automatic model_step();
        bit ren;
        bit pop;
        int wb;
        if (rrst_i) begin
            m_rbin = 0;
            m_empty = 1;
            m_aempty = 1;
            m_infl = 0;
            m_buf.delete();
            outst = 0;
        end else begin
            ren = model_ren();
            pop = (m_buf.size() != 0) && dout_ready;
            outst = outst + int'(seen_ren) - int'(seen_pop);
            if (pop) void'(m_buf.pop_front());
            if (m_infl) m_buf.push_back(m_infl_data);
            m_infl = ren;
            if (ren) m_infl_data = ram[m_rbin % 16];
            m_rbin = (m_rbin + int'(ren)) % 32;
            wb = g2b(int'(wptr));
            m_empty = (wb == m_rbin);
            m_aempty = (((wb - m_rbin + 32) % 32) <= 1);
        end
        cyc++;
    endtask

    task automatic compare_now();
        bit er;
        er = model_ren();
        chk("rd_en", rd_en, er);
        if (er) chk("rd_addr", rd_addr, m_rbin % 16);
        chk("fifo_empty", fifo_empty, m_empty);
        chk("fifo_almost_empty", fifo_almost_empty, m_aempty);
        chk("rptr_g", rptr_g, b2g(m_rbin));
        chk("dout_valid", dout_valid, m_buf.size() != 0);
        if (m_buf.size() != 0) chk("dout", dout, m_buf[0]);
        chk("occupancy", outst, m_buf.size() + int'(m_infl));
        chk("overflow", outst <= 2, 1);
        if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got %0h, expected no beat (cycle %0d)", dout, cyc);
            end else begin
                chk("stream_data", dout, exp_q.pop_front());
            end
            beat_cyc.push_back(cyc);
        end
        if (rd_en) begin
            ren_cnt++;
            addr_log.push_back(int'(rd_addr));
        end
        seen_ren = rd_en;
        seen_pop = dout_valid & dout_ready;
    endtask

    task automatic compare_loop();
        forever begin
            @(posedge rclk_i);
            model_step();
            @(negedge rclk_i);
            compare_now();
        end
    endtask

    task automatic do_reset();
        rrst_i = 1'b1;
        wptr = 5'b00000;
        repeat (2) tick();
        rrst_i = 1'b0;
        exp_q.delete();
        tick();
    endtask

    initial begin
        int b;
        int r;
        int a;
        rrst_i = 1'b1;
        wptr = 5'b00011;
        dout_ready = 1'b0;
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;

        // Reset with a non-zero synced write pointer
        tick();
        @(negedge rclk_i);
        chk("rst_rd_en_1", rd_en, 0);
        tick();
        @(negedge rclk_i);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_aempty", fifo_almost_empty, 1);
        chk("rst_rptr_g", rptr_g, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_rd_en_2", rd_en, 0);
        tick();
        rrst_i = 1'b0;
        wptr = 5'b00000;
        dout_ready = 1'b1;
        tick();
        fork
            compare_loop();
        join_none

        // Single word
        ram[0] = 8'hA5;
        exp_q.push_back(8'hA5);
        wptr = 5'b00001;
        @(negedge rclk_i);
        chk("sw_rd_en_before", rd_en, 0);
        tick();
        @(negedge rclk_i);
        chk("sw_empty_fell", fifo_empty, 0);
        chk("sw_rd_en", rd_en, 1);
        chk("sw_rd_addr", rd_addr, 0);
        tick();
        @(negedge rclk_i);
        chk("sw_rd_en_drop", rd_en, 0);
        chk("sw_empty_again", fifo_empty, 1);
        chk("sw_rptr_g", rptr_g, 5'b00001);
        chk("sw_valid_early", dout_valid, 0);
        tick();
        @(negedge rclk_i);
        chk("sw_valid", dout_valid, 1);
        chk("sw_dout", dout, 8'hA5);
        tick();
        @(negedge rclk_i);
        chk("sw_valid_after", dout_valid, 0);
        tick();

        // Streaming 16 words
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ram[i] = 8'(i * 13 + 7);
            exp_q.push_back(8'(i * 13 + 7));
        end
        b = beat_cyc.size();
        r = ren_cnt;
        wptr = 5'b11000;
        repeat (22) tick();
        @(negedge rclk_i);
        chk("st_beats", beat_cyc.size() - b, 16);
        if (beat_cyc.size() - b == 16) chk("st_gapless", beat_cyc[b+15] - beat_cyc[b], 15);
        chk("st_reads", ren_cnt - r, 16);
        chk("st_empty", fifo_empty, 1);
        chk("st_aempty", fifo_almost_empty, 1);
        chk("st_rptr_g", rptr_g, 5'b11000);
        chk("st_all_seen", exp_q.size(), 0);
        tick();

        // Backpressure: 8 words, consumer stalled
        do_reset();
        dout_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ram[i] = 8'(8'h40 + i);
            exp_q.push_back(8'(8'h40 + i));
        end
        b = beat_cyc.size();
        r = ren_cnt;
        wptr = 5'b01100;
        repeat (10) tick();
        @(negedge rclk_i);
        chk("bp_reads", ren_cnt - r, 2);
        chk("bp_held", outst, 2);
        chk("bp_valid", dout_valid, 1);
        chk("bp_head", dout, 8'h40);
        chk("bp_rd_en", rd_en, 0);
        tick();
        dout_ready = 1'b1;
        repeat (12) tick();
        @(negedge rclk_i);
        chk("bp_beats", beat_cyc.size() - b, 8);
        if (beat_cyc.size() - b == 8) chk("bp_gapless", beat_cyc[b+7] - beat_cyc[b], 7);
        chk("bp_reads_total", ren_cnt - r, 8);
        chk("bp_empty", fifo_empty, 1);
        chk("bp_all_seen", exp_q.size(), 0);
        tick();

        // Wrap: advance to 30, then four more words
        do_reset();
        for (int i = 0; i < 16; i++) ram[i] = 8'(i);
        for (int k = 0; k < 30; k++) exp_q.push_back(8'(k % 16));
        wptr = 5'b10001;
        repeat (36) tick();
        @(negedge rclk_i);
        chk("wr_pre_rptr_g", rptr_g, 5'b10001);
        chk("wr_pre_empty", fifo_empty, 1);
        tick();
        ram[14] = 8'hC0;
        ram[15] = 8'hC1;
        ram[0]  = 8'hC2;
        ram[1]  = 8'hC3;
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'hC0 + k));
        a = addr_log.size();
        wptr = 5'b00011;
        repeat (8) tick();
        @(negedge rclk_i);
        chk("wr_reads", addr_log.size() - a, 4);
        if (addr_log.size() - a == 4) begin
            chk("wr_addr0", addr_log[a], 14);
            chk("wr_addr1", addr_log[a+1], 15);
            chk("wr_addr2", addr_log[a+2], 0);
            chk("wr_addr3", addr_log[a+3], 1);
        end
        chk("wr_rptr_g", rptr_g, 5'b00011);
        chk("wr_empty", fifo_empty, 1);
        chk("wr_all_seen", exp_q.size(), 0);
        tick();

        // Reset while a read is in flight
        do_reset();
        ram[0] = 8'h3C;
        b = beat_cyc.size();
        wptr = 5'b00001;
        tick();
        tick();
        rrst_i = 1'b1;
        wptr = 5'b00000;
        @(negedge rclk_i);
        chk("mr_rd_data", rd_data_i, 8'h3C);
        tick();
        @(negedge rclk_i);
        chk("mr_rptr_g", rptr_g, 0);
        chk("mr_empty", fifo_empty, 1);
        chk("mr_aempty", fifo_almost_empty, 1);
        chk("mr_valid", dout_valid, 0);
        chk("mr_dout", dout, 0);
        chk("mr_rd_en", rd_en, 0);
        tick();
        rrst_i = 1'b0;
        repeat (5) tick();
        @(negedge rclk_i);
        chk("mr_no_beats", beat_cyc.size() - b, 0);
        chk("mr_valid_later", dout_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
